fp_addsub_seq: RTL and testbench

Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on input and output. It unpacks two operands, aligns exponents, adds or subtracts significands, normalises, rounds and repacks the result, and raises status flags. It is the datapath engine behind the calculator control FSM and runs directly on the system clock, with no clock divider.

---
 rtl/fp_addsub_seq.sv | 217 +++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes on both sides.
// Define FP_ROUND_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags,
   output logic [2:0]   dbg_state
);
   localparam int SIG_W = MAN_W + 5;            // carry, hidden, mantissa, G, R, S
   localparam int EW    = EXP_W + 2;            // signed working exponent
   localparam int LZ_W  = $clog2(SIG_W) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ALIGN = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_NORM  = 3'd3;
   localparam logic [2:0] S_ROUND = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
   localparam logic signed [EW-1:0] E_ZERO   = '0;
   localparam logic signed [EW-1:0] E_ONES   = {2'b00, {EXP_W{1'b1}}};
   localparam logic [W-1:0]         CNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   logic [2:0]              state;
   logic [W-1:0]            a_r, b_r;
   logic                    op_r;
   logic [SIG_W-1:0]        xs_r, ys_r, sum_r;
   logic signed [EW-1:0]    ex_r;
   logic                    sx_r, eff_sub_r, zsign_r, zero_r;
   logic                    spec_r;
   logic [W-1:0]            spec_res_r;
   logic [3:0]              spec_fl_r;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign dbg_state = state;

   function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-2:0] v);
      lzc = LZ_W'(SIG_W - 1);
      for (int i = 0; i <= SIG_W - 2; i++)
         if (v[i]) lzc = LZ_W'(SIG_W - 2 - i);
   endfunction

   // Unpack, special-case resolution and alignment of the smaller operand
   logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [EXP_W-1:0] ea, eb, ex_n, ey_n, d;
   logic [MAN_W-1:0] ma, mb;
   logic [SIG_W-1:0] siga, sigb, xs_n, ys_src, ys_n;
   logic [W-1:0]     spec_res_n;
   logic [3:0]       spec_fl_n;

   always_comb begin
      sa     = a_r[W-1];
      sb     = b_r[W-1] ^ op_r;
      ea     = a_r[W-2:MAN_W];
      eb     = b_r[W-2:MAN_W];
      ma     = a_r[MAN_W-1:0];
      mb     = b_r[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == EXP_ONES) && (ma == '0);
      b_inf  = (eb == EXP_ONES) && (mb == '0);
      a_nan  = (ea == EXP_ONES) && (ma != '0);
      b_nan  = (eb == EXP_ONES) && (mb != '0);
      siga   = a_zero ? '0 : {2'b01, ma, 3'b000};
      sigb   = b_zero ? '0 : {2'b01, mb, 3'b000};
      swap   = {(a_zero ? '0 : ea), (a_zero ? '0 : ma)} < {(b_zero ? '0 : eb), (b_zero ? '0 : mb)};
      ex_n   = swap ? eb : (a_zero ? '0 : ea);
      ey_n   = swap ? (a_zero ? '0 : ea) : (b_zero ? '0 : eb);
      xs_n   = swap ? sigb : siga;
      ys_src = swap ? siga : sigb;
      d      = ex_n - ey_n;
      if (32'(d) >= MAN_W + 3)
         ys_n = {{(SIG_W-1){1'b0}}, |ys_src};
      else
         ys_n = (ys_src >> d) | {{(SIG_W-1){1'b0}}, |(ys_src & ~({SIG_W{1'b1}} << d))};
      spec_res_n = '0;
      spec_fl_n  = 4'b0000;
      if (a_nan || b_nan) begin
         spec_res_n = CNAN;
      end else if (a_inf && b_inf && (sa != sb)) begin
         spec_res_n = CNAN;
         spec_fl_n  = 4'b1000;
      end else if (a_inf) begin
         spec_res_n = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_res_n = {sb, EXP_ONES, {MAN_W{1'b0}}};
      end
   end

   // Normalisation: carry shifts right keeping sticky, otherwise shift out leading zeros
   logic [LZ_W-1:0]  lz;
   logic [SIG_W-1:0] norm_n;
   logic [EW-1:0]    enorm_n;

   always_comb begin
      lz = lzc(sum_r[SIG_W-2:0]);
      if (sum_r[SIG_W-1]) begin
         norm_n  = {1'b0, sum_r[SIG_W-1:2], sum_r[1] | sum_r[0]};
         enorm_n = ex_r + EW'(1);
      end else begin
         norm_n  = sum_r << lz;
         enorm_n = ex_r - EW'(lz);
      end
   end

   // Rounding, range checks and final packing
   logic [MAN_W:0]       mant;
   logic                 inexact, inc;
   logic [MAN_W+1:0]     rnd;
   logic [MAN_W-1:0]     man_f;
   logic signed [EW-1:0] exp_f;
   logic [W-1:0]         res_n;
   logic [3:0]           fl_n;

   always_comb begin
      mant    = sum_r[SIG_W-2:3];
      inexact = |sum_r[2:0];
`ifdef FP_ROUND_RNE_EN
      inc     = sum_r[2] & (sum_r[1] | sum_r[0] | mant[0]);
`else
      inc     = 1'b0;
`endif
      rnd     = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
      man_f   = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      exp_f   = ex_r + $signed(EW'(rnd[MAN_W+1]));
      if (spec_r) begin
         res_n = spec_res_r;
         fl_n  = spec_fl_r;
      end else if (zero_r) begin
         res_n = {zsign_r, {(W-1){1'b0}}};
         fl_n  = 4'b0000;
      end else if (exp_f >= E_ONES) begin
         res_n = {sx_r, EXP_ONES, {MAN_W{1'b0}}};
         fl_n  = 4'b0101;
      end else if (exp_f <= E_ZERO) begin
         res_n = {sx_r, {(W-1){1'b0}}};
         fl_n  = 4'b0011;
      end else begin
         res_n = {sx_r, exp_f[EXP_W-1:0], man_f};
         fl_n  = {3'b000, inexact};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         a_r        <= '0;
         b_r        <= '0;
         op_r       <= 1'b0;
         xs_r       <= '0;
         ys_r       <= '0;
         sum_r      <= '0;
         ex_r       <= '0;
         sx_r       <= 1'b0;
         eff_sub_r  <= 1'b0;
         zsign_r    <= 1'b0;
         zero_r     <= 1'b0;
         spec_r     <= 1'b0;
         spec_res_r <= '0;
         spec_fl_r  <= '0;
         result     <= '0;
         flags      <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               a_r   <= a;
               b_r   <= b;
               op_r  <= op_sel;
               state <= S_ALIGN;
            end
            S_ALIGN: begin
               xs_r       <= xs_n;
               ys_r       <= ys_n;
               ex_r       <= $signed({2'b00, ex_n});
               sx_r       <= swap ? sb : sa;
               eff_sub_r  <= sa ^ sb;
               zsign_r    <= sa & sb;
               spec_r     <= a_nan | b_nan | a_inf | b_inf;
               spec_res_r <= spec_res_n;
               spec_fl_r  <= spec_fl_n;
               state      <= S_ADD;
            end
            S_ADD: begin
               sum_r <= eff_sub_r ? (xs_r - ys_r) : (xs_r + ys_r);
               state <= S_NORM;
            end
            S_NORM: begin
               zero_r <= (sum_r == '0);
               sum_r  <= norm_n;
               ex_r   <= enorm_n;
               state  <= S_ROUND;
            end
            S_ROUND: begin
               result <= res_n;
               flags  <= fl_n;
               state  <= S_DONE;
            end
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: arithmetic vectors, specials, rounding,
// backpressure and mid-operation reset against hand-computed results.
module tb_fp_addsub_seq;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_ready, op_sel, out_valid, out_ready;
   logic [W-1:0] a, b, result;
   logic [3:0]   flags;
   logic [2:0]   dbg_state;

   int n_assert = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [3:0]   expf_q[$];

   fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic op);
      @(negedge clk);
      a = av; b = bv; op_sel = op; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
   endtask

   task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic op, input logic [W-1:0] er, input logic [3:0] ef);
      int lat;
      exp_q.push_back(er);
      expf_q.push_back(ef);
      send(av, bv, op);
      wait_valid(tag, lat);
      check({tag, "_result"}, result, exp_q.pop_front());
      check({tag, "_flags"}, 32'(flags), 32'(expf_q.pop_front()));
      @(posedge clk);
      #1 check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
   endtask

   initial begin
      int lat;
      logic [W-1:0] tie_exp;
      reset = 1'b0; in_valid = 1'b0; op_sel = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_flags", 32'(flags), 32'd0);
      @(negedge clk) reset = 1'b1;

      run("one_plus_two",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      check("hold_in_idle", result, 32'h40400000);
      run("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
      run("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
      run("three_minus_one",32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000);
      run("one_minus_two",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
      run("max_plus_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
      run("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
      run("nan_plus_one",   32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
      run("one_plus_ninf",  32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);
      run("underflow",      32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
`ifdef FP_ROUND_RNE_EN
      tie_exp = 32'h3F800002;
`else
      tie_exp = 32'h3F800001;
`endif
      run("tie_round",      32'h3F800001, 32'h33800000, 1'b0, tie_exp, 4'b0001);

      // Backpressure: result must stay put and no new operands be taken
      out_ready = 1'b0;
      send(32'h40000000, 32'h3F800000, 1'b0);
      wait_valid("bp", lat);
      @(negedge clk);
      a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result", result, 32'h40400000);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
      run("after_bp", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000);

      // Reset during NORM aborts the operation
      send(32'h3F800000, 32'h3F800000, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 check("mid_state_norm", 32'(dbg_state), 32'd3);
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_result", result, 32'h0);
      @(negedge clk) reset = 1'b1;
      run("two_plus_two", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
